// File: rtl/skew_meas_pkg.sv
// Shared types for the skew measurement controller: FSM state encoding and counter widths.
package skew_meas_pkg;

    localparam int SETTLE_CNT_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SETTLE,
        S_SAMPLE,
        S_REPORT
    } skew_state_t;

endpackage

// File: rtl/skew_meas_accum.sv
// Sample statistics for one skew measurement: running sum, saturation flag and
// (with SKEW_MINMAX_EN defined) min/max tracking.
module skew_meas_accum #(
    parameter int STAGES = 64,
    parameter int CODE_W = 7,
    parameter int NLOG2  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    en,
    input  logic [CODE_W-1:0]       code,
    output logic [CODE_W+NLOG2-1:0] acc,
`ifdef SKEW_MINMAX_EN
    output logic [CODE_W-1:0]       min_code,
    output logic [CODE_W-1:0]       max_code,
`endif
    output logic                    sat
);

    localparam int ACC_W = CODE_W + NLOG2;

    // ACC_W leaves NLOG2 bits of headroom, enough for 2^NLOG2 full-scale codes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            sat <= 1'b0;
        end else if (clr) begin
            acc <= '0;
            sat <= 1'b0;
        end else if (en) begin
            acc <= acc + ACC_W'(code);
            if (code == CODE_W'(STAGES))
                sat <= 1'b1;
        end
    end

`ifdef SKEW_MINMAX_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_code <= '0;
            max_code <= '0;
        end else if (clr) begin
            min_code <= '1;
            max_code <= '0;
        end else if (en) begin
            if (code < min_code) min_code <= code;
            if (code > max_code) max_code <= code;
        end
    end
`endif

endmodule

// File: rtl/skew_meas_ctrl.sv
// Skew TDC measurement sequencer: clear, settle, average 2^NLOG2 samples, report.
// Optional min/max statistics are built when SKEW_MINMAX_EN is defined.
module skew_meas_ctrl
    import skew_meas_pkg::*;
#(
    parameter int STAGES = 64,
    parameter int NLOG2  = 4,
    parameter int SETTLE = 4,
    localparam int CODE_W = $clog2(STAGES + 1),
    localparam int ACC_W  = CODE_W + NLOG2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [CODE_W-1:0] code_in,
    output logic              tdc_clr,
    output logic              tdc_en,
    output logic              busy,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [CODE_W-1:0] res_avg,
    output logic [CODE_W-1:0] res_min,
    output logic [CODE_W-1:0] res_max,
    output logic              res_sat
);

    localparam int NSAMP = 1 << NLOG2;
    localparam int SC_W  = NLOG2 + 1;

    skew_state_t             state;
    logic [SETTLE_CNT_W-1:0] settle_cnt;
    logic [SC_W-1:0]         samp_cnt;
    logic [ACC_W-1:0]        acc;
    logic                    sat;
`ifdef SKEW_MINMAX_EN
    logic [CODE_W-1:0]       min_code, max_code;
`endif

    skew_meas_accum #(
        .STAGES (STAGES),
        .CODE_W (CODE_W),
        .NLOG2  (NLOG2)
    ) u_accum (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (state == S_CLEAR),
        .en       (state == S_SAMPLE),
        .code     (code_in),
        .acc      (acc),
`ifdef SKEW_MINMAX_EN
        .min_code (min_code),
        .max_code (max_code),
`endif
        .sat      (sat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            settle_cnt <= '0;
            samp_cnt   <= '0;
            tdc_clr    <= 1'b0;
            tdc_en     <= 1'b0;
            busy       <= 1'b0;
            res_valid  <= 1'b0;
            res_avg    <= '0;
            res_sat    <= 1'b0;
`ifdef SKEW_MINMAX_EN
            res_min    <= '0;
            res_max    <= '0;
`endif
        end else if (abort && state != S_IDLE) begin
            state     <= S_IDLE;
            tdc_clr   <= 1'b0;
            tdc_en    <= 1'b0;
            busy      <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    state   <= S_CLEAR;
                    tdc_clr <= 1'b1;
                    busy    <= 1'b1;
                end
                S_CLEAR: begin
                    state      <= S_SETTLE;
                    tdc_clr    <= 1'b0;
                    tdc_en     <= 1'b1;
                    settle_cnt <= '0;
                end
                S_SETTLE: begin
                    if (settle_cnt == SETTLE_CNT_W'(SETTLE - 1)) begin
                        state    <= S_SAMPLE;
                        samp_cnt <= '0;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                S_SAMPLE: begin
                    if (samp_cnt == SC_W'(NSAMP - 1)) begin
                        state  <= S_REPORT;
                        tdc_en <= 1'b0;
                    end else begin
                        samp_cnt <= samp_cnt + 1'b1;
                    end
                end
                S_REPORT: begin
                    // First REPORT cycle latches the statistics once the last sample has landed.
                    if (!res_valid) begin
                        res_valid <= 1'b1;
                        res_avg   <= CODE_W'(acc >> NLOG2);
                        res_sat   <= sat;
`ifdef SKEW_MINMAX_EN
                        res_min   <= min_code;
                        res_max   <= max_code;
`endif
                    end else if (res_ready) begin
                        state     <= S_IDLE;
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    tdc_clr <= 1'b0;
                    tdc_en  <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

`ifndef SKEW_MINMAX_EN
    assign res_min = '0;
    assign res_max = '0;
`endif

endmodule

// File: tb/tb_skew_meas_ctrl.sv
// Randomized scoreboard bench for skew_meas_ctrl (STAGES=64, NLOG2=2, SETTLE=3).
module tb_skew_meas_ctrl;

    localparam int STAGES = 64;
    localparam int NLOG2  = 2;
    localparam int SETTLE = 3;
    localparam int CODE_W = 7;
    localparam int NS     = 4;
    localparam int LAT    = 2 + SETTLE + NS;

    logic              clk = 1'b0, rst_n = 1'b1;
    logic              start = 1'b0, abort = 1'b0, res_ready = 1'b0;
    logic [CODE_W-1:0] code_in = '0;
    logic              tdc_clr, tdc_en, busy, res_valid, res_sat;
    logic [CODE_W-1:0] res_avg, res_min, res_max;

    skew_meas_ctrl #(.STAGES(STAGES), .NLOG2(NLOG2), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .code_in(code_in),
        .tdc_clr(tdc_clr), .tdc_en(tdc_en), .busy(busy), .res_valid(res_valid),
        .res_ready(res_ready), .res_avg(res_avg), .res_min(res_min), .res_max(res_max),
        .res_sat(res_sat)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int avg;
        int mn;
        int mx;
        int sat;
        int t0;
    } exp_t;

    exp_t q[$];
    int checks = 0, errors = 0;
    int last_avg = 0, last_min = 0, last_max = 0, last_sat = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every rising res_valid pops one expected result; held results must not move.
    bit   prev_v = 1'b0;
    int   s_avg, s_min, s_max, s_sat;
    exp_t e;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (res_valid && !prev_v) begin
                if (q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("latency", cyc - 1 - e.t0, LAT);
                    chk("avg", int'(res_avg), e.avg);
                    chk("min", int'(res_min), e.mn);
                    chk("max", int'(res_max), e.mx);
                    chk("sat", int'(res_sat), e.sat);
                    last_avg = e.avg; last_min = e.mn; last_max = e.mx; last_sat = e.sat;
                end
                s_avg = res_avg; s_min = res_min; s_max = res_max; s_sat = res_sat;
            end else if (res_valid) begin
                chk("hold_stable", int'(res_avg == s_avg && res_min == s_min &&
                                        res_max == s_max && res_sat == s_sat), 1);
            end
            prev_v = res_valid;
        end
    end

    function automatic int rnd_code();
        return ($urandom_range(0, 3) == 0) ? STAGES : int'($urandom_range(0, STAGES));
    endfunction

    // Issue start, drive the four sampled codes, then handshake the result out.
    task automatic meas(input int c0, input int c1, input int c2, input int c3,
                        input int rdy_dly, input bit poke_start);
        int   c[4];
        int   sum, mn, mx, st, n;
        exp_t x;
        c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3;
        sum = 0; mn = 1 << CODE_W; mx = -1; st = 0;
        foreach (c[i]) begin
            sum += c[i];
            if (c[i] < mn) mn = c[i];
            if (c[i] > mx) mx = c[i];
            if (c[i] == STAGES) st = 1;
        end
`ifndef SKEW_MINMAX_EN
        mn = 0; mx = 0;
`endif
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        x.avg = sum / NS; x.mn = mn; x.mx = mx; x.sat = st; x.t0 = cyc;
        q.push_back(x);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0;
                chk("clr_strobe", int'(tdc_clr && busy), 1);
            end
            if (k == 2) chk("en_after_clr", int'(tdc_en && !tdc_clr), 1);
            code_in = (k >= 5) ? CODE_W'(c[k-5]) : CODE_W'($urandom_range(0, STAGES));
        end
        n = 0;
        while (!res_valid && n < 20) begin
            @(negedge clk);
            code_in = CODE_W'($urandom_range(0, STAGES));
            n++;
        end
        if (!res_valid) chk("valid_timeout", 0, 1);
        chk("en_off_report", int'(tdc_en), 0);
        for (int d = 0; d < rdy_dly; d++) begin
            if (poke_start && d == 0) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("release_idle", int'(!busy && !res_valid), 1);
        if (poke_start) begin
            @(negedge clk);
            chk("start_ignored", int'(busy), 0);
        end
    endtask

    initial begin
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", int'({tdc_clr, tdc_en, busy, res_valid, res_sat} == 5'b0 &&
                                  res_avg == 0 && res_min == 0 && res_max == 0), 1);
        rst_n = 1'b1;

        meas(10, 12, 14, 16, 0, 1'b0);
        meas(64, 64, 64, 63, 1, 1'b0);
        meas(20, 30, 40, 51, 5, 1'b1);

        // Abort on the second SAMPLE cycle: no result, previous statistics retained.
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            start   = 1'b0;
            code_in = CODE_W'($urandom_range(0, STAGES));
        end
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        chk("abort_idle", int'(!busy && !tdc_en && !res_valid), 1);
        chk("abort_keep_avg", int'(res_avg), last_avg);
        chk("abort_keep_min", int'(res_min), last_min);
        chk("abort_keep_max", int'(res_max), last_max);
        chk("abort_keep_sat", int'(res_sat), last_sat);
        repeat (15) @(negedge clk);

        // Asynchronous reset while settling.
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        repeat (3) @(negedge clk) start = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk("async_reset", int'({tdc_clr, tdc_en, busy, res_valid, res_sat} == 5'b0 &&
                                   res_avg == 0 && res_min == 0 && res_max == 0), 1);
        last_avg = 0; last_min = 0; last_max = 0; last_sat = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("no_result_after_reset", int'(busy || res_valid), 0);
        meas(5, 6, 7, 9, 0, 1'b0);

        for (int r = 0; r < 10; r++)
            meas(rnd_code(), rnd_code(), rnd_code(), rnd_code(),
                 int'($urandom_range(0, 3)), 1'b0);

        repeat (5) @(negedge clk);
        chk("all_results_seen", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
